// File: rtl/serial_pkg.sv
// Shared definitions for the UART-style serial link with XOR parity.
// The receiver and the matching transmitter both use these.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Reset presets both flops to 1, the idle level of a serial line.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: start, DATA_BITS data LSB-first, parity, stop.
// Samples mid-bit, checks XOR parity and reports framing errors.
module serial_parity_rx #(
  parameter int unsigned CLKS_PER_BIT = serial_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_ODD   = serial_pkg::PARITY_EVEN
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  import serial_pkg::*;

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW   = $clog2(DATA_BITS);

  localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q;
  logic [TimerW-1:0]    timer_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 acc_q;
  logic                 parity_bad_q;
  logic                 rx_prev_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      parity_bad_q <= 1'b0;
      rx_prev_q    <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // History runs in every state so a start bit right after a stop bit is seen.
      rx_prev_q <= rx_s;
      valid_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s) begin
            state_q <= StStart;
            timer_q <= '0;
          end
        end

        StStart: begin
          if (timer_q == HalfBit) begin
            timer_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
              acc_q     <= PARITY_ODD;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StData: begin
          if (timer_q == FullBit) begin
            timer_q <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            acc_q   <= acc_q ^ rx_s;
            if (bit_idx_q == LastIdx) begin
              state_q <= StParity;
            end else begin
              bit_idx_q <= bit_idx_q + IdxW'(1);
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StParity: begin
          if (timer_q == FullBit) begin
            timer_q      <= '0;
            parity_bad_q <= acc_q ^ rx_s;
            state_q      <= StStop;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StStop: begin
          if (timer_q == FullBit) begin
            timer_q      <= '0;
            state_q      <= StIdle;
            valid_q      <= 1'b1;
            data_q       <= shift_q;
            parity_err_q <= parity_bad_q;
            frame_err_q  <= ~rx_s;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = parity_err_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = (state_q != StIdle);

endmodule
